// File: rtl/stack_reg_param_if.sv
// stack_reg_param_if: push/pop request and stack status bundle for stack_reg_param
interface stack_reg_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic             flush;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             udf;
  logic [1:0]       err_sticky;
  modport master (
    output data_in, push, pop, flush, err_clr,
    input  data_out, count, empty, full, ovf, udf, err_sticky
  );
  modport slave (
    input  data_in, push, pop, flush, err_clr,
    output data_out, count, empty, full, ovf, udf, err_sticky
  );
endinterface

// File: rtl/stack_reg_param.sv
// stack_reg_param: parametrised LIFO register stack with zero-latency top, flags and sticky errors
// STACK_REG_PEEK_EN adds a combinational peek_idx/peek_data read port for debug.
module stack_reg_param #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 8,
  parameter int DROP_ON_FULL = 1
) (
  input  logic                     sysclk,
  input  logic                     sysreset_n,
  stack_reg_param_if.slave         bus
`ifdef STACK_REG_PEEK_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [WIDTH-1:0]         peek_data
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] e     [DEPTH];
  logic [WIDTH-1:0] e_nxt [DEPTH];
  logic [CW-1:0]    count, count_nxt;
  logic             ovf, ovf_nxt, udf, udf_nxt;
  logic [1:0]       sticky, sticky_nxt;
  logic             empty, full;
  assign empty          = count == '0;
  assign full           = count == CW'(DEPTH);
  assign bus.data_out   = e[0];
  assign bus.count      = count;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.ovf        = ovf;
  assign bus.udf        = udf;
  assign bus.err_sticky = sticky;
`ifdef STACK_REG_PEEK_EN
  assign peek_data = (32'(peek_idx) < DEPTH) ? e[peek_idx] : '0;
`endif
  // flush beats everything; push+pop on a non-empty stack only rewrites the top
  always_comb begin
    e_nxt     = e;
    count_nxt = count;
    ovf_nxt   = 1'b0;
    udf_nxt   = 1'b0;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) e_nxt[i] = '0;
      count_nxt = '0;
    end else if (bus.push && bus.pop && !empty) begin
      e_nxt[0] = bus.data_in;
    end else if (bus.push) begin
      ovf_nxt = full;
      if (!full || DROP_ON_FULL != 0) begin
        e_nxt[0] = bus.data_in;
        for (int i = 1; i < DEPTH; i++) e_nxt[i] = e[i-1];
      end
      count_nxt = full ? count : count + CW'(1);
    end else if (bus.pop) begin
      udf_nxt = empty;
      if (!empty) begin
        for (int i = 0; i < DEPTH - 1; i++) e_nxt[i] = e[i+1];
        e_nxt[DEPTH-1] = '0;
        count_nxt = count - CW'(1);
      end
    end
    sticky_nxt = bus.flush ? 2'b00 : ((bus.err_clr ? 2'b00 : sticky) | {ovf_nxt, udf_nxt});
  end
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      for (int i = 0; i < DEPTH; i++) e[i] <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      sticky <= 2'b00;
    end else begin
      e      <= e_nxt;
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      udf    <= udf_nxt;
      sticky <= sticky_nxt;
    end
  end
endmodule

// File: tb/tb_stack_reg_param.sv
// tb_stack_reg_param: directed scoreboard bench; a queue model predicts every cycle's outputs
module tb_stack_reg_param;
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  c;
    logic        e, f, o, u;
    logic [1:0]  s;
  } exp_t;
  logic sysclk = 1'b0;
  logic sysreset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] m [$];
  logic [1:0]  ms = 2'b00;
  logic        mo = 1'b0, mu = 1'b0;
  exp_t        exp_q [$];
  stack_reg_param_if #(.WIDTH(16), .DEPTH(8)) b0 ();
  stack_reg_param_if #(.WIDTH(16), .DEPTH(8)) b1 ();
`ifdef STACK_REG_PEEK_EN
  logic [2:0]  pk = 3'd0;
  logic [15:0] pd0, pd1;
`endif
  stack_reg_param #(.WIDTH(16), .DEPTH(8), .DROP_ON_FULL(1)) u_drop (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .bus(b0)
`ifdef STACK_REG_PEEK_EN
    , .peek_idx(pk), .peek_data(pd0)
`endif
  );
  stack_reg_param #(.WIDTH(16), .DEPTH(8), .DROP_ON_FULL(0)) u_keep (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .bus(b1)
`ifdef STACK_REG_PEEK_EN
    , .peek_idx(pk), .peek_data(pd1)
`endif
  );
  always #5 sysclk = ~sysclk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_push();
    exp_t x;
    x.d = m.size() > 0 ? m[0] : 16'h0;
    x.c = 4'(m.size());
    x.e = m.size() == 0;
    x.f = m.size() == 8;
    x.o = mo;
    x.u = mu;
    x.s = ms;
    exp_q.push_back(x);
  endtask
  task automatic compare();
    exp_t x;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = exp_q.pop_front();
    check("top",    32'(b0.data_out),   32'(x.d));
    check("count",  32'(b0.count),      32'(x.c));
    check("empty",  32'(b0.empty),      32'(x.e));
    check("full",   32'(b0.full),       32'(x.f));
    check("ovf",    32'(b0.ovf),        32'(x.o));
    check("udf",    32'(b0.udf),        32'(x.u));
    check("sticky", 32'(b0.err_sticky), 32'(x.s));
  endtask
  task automatic model(input logic ps, pp, fl, cl, input logic [15:0] d);
    mo = 1'b0;
    mu = 1'b0;
    if (fl) begin
      m.delete();
      ms = 2'b00;
    end else begin
      if (ps && pp && m.size() > 0) m[0] = d;
      else if (ps) begin
        if (m.size() == 8) begin
          mo = 1'b1;
          void'(m.pop_back());
        end
        m.push_front(d);
      end else if (pp) begin
        if (m.size() > 0) void'(m.pop_front());
        else mu = 1'b1;
      end
      ms = (cl ? 2'b00 : ms) | {mo, mu};
    end
  endtask
  task automatic step(input logic ps, pp, fl, cl, input logic [15:0] d);
    b0.push = ps; b0.pop = pp; b0.flush = fl; b0.err_clr = cl; b0.data_in = d;
    b1.push = ps; b1.pop = pp; b1.flush = fl; b1.err_clr = cl; b1.data_in = d;
    model(ps, pp, fl, cl, d);
    expect_push();
    @(posedge sysclk);
    #1;
    compare();
  endtask
  task automatic model_reset();
    m.delete();
    ms = 2'b00;
    mo = 1'b0;
    mu = 1'b0;
  endtask
  initial begin
    b0.push = 0; b0.pop = 0; b0.flush = 0; b0.err_clr = 0; b0.data_in = '0;
    b1.push = 0; b1.pop = 0; b1.flush = 0; b1.err_clr = 0; b1.data_in = '0;
    #2;
    model_reset();
    expect_push();
    compare();
    @(posedge sysclk);
    #1;
    sysreset_n = 1'b1;
    // reset asserted in the middle of a push burst clears outputs immediately
    step(1, 0, 0, 0, 16'h0010);
    step(1, 0, 0, 0, 16'h0020);
    b0.push = 1; b0.data_in = 16'h0030;
    b1.push = 1; b1.data_in = 16'h0030;
    #2;
    sysreset_n = 1'b0;
    #1;
    model_reset();
    expect_push();
    compare();
    @(posedge sysclk);
    #1;
    b0.push = 0; b1.push = 0;
    sysreset_n = 1'b1;
    step(0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h1111);
    step(1, 0, 0, 0, 16'h2222);
    step(1, 0, 0, 0, 16'h3333);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'h0);
    // overflow: drop-bottom instance vs. ignore instance
    step(0, 0, 1, 0, 16'h0);
    for (int i = 1; i <= 9; i++) step(1, 0, 0, 0, 16'(i));
    check("keep_top",   32'(b1.data_out), 32'd8);
    check("keep_count", 32'(b1.count),    32'd8);
    check("keep_ovf",   32'(b1.ovf),      32'd1);
    step(0, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 16'h0);
      check("keep_pop_top", 32'(b1.data_out), 32'(8 - i));
    end
    check("keep_empty", 32'(b1.empty), 32'd1);
    step(0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    step(0, 1, 0, 1, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    // replace-top keeps entry below intact
    step(1, 0, 0, 0, 16'h0A01);
    step(1, 0, 0, 0, 16'h0A02);
    step(1, 0, 0, 0, 16'h0A03);
    step(1, 1, 0, 0, 16'hABCD);
    step(0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h0);
    step(1, 1, 0, 0, 16'h5555);
    step(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 16'(16'hC000 + i));
    step(1, 1, 0, 0, 16'hF00D);
    step(1, 0, 0, 0, 16'hEEEE);
    step(1, 0, 1, 0, 16'hBEEF);
    step(1, 0, 0, 0, 16'h000A);
    step(1, 0, 0, 0, 16'h000B);
    step(1, 0, 0, 0, 16'h000C);
    step(1, 0, 0, 0, 16'h000D);
`ifdef STACK_REG_PEEK_EN
    pk = 3'd2;
    #1;
    check("peek2", 32'(pd0), 32'h000B);
    pk = 3'd0;
    #1;
    check("peek0", 32'(pd0), 32'h000D);
    pk = 3'd5;
    #1;
    check("peek_vacant", 32'(pd0), 32'h0);
`endif
    step(0, 0, 0, 0, 16'h0);
    if (exp_q.size() != 0) check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #50000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
